// File: rtl/riscv_pipe_pkg.sv
// Shared widths and bundle layouts for the RISC-V pipeline stage registers.
// Each stage has a packed data struct and a packed control struct that cast to and from the flat ports of pipe_stage_reg.
package riscv_pipe_pkg;

  // IF/ID carries no control; one reserved bit keeps the control port non-empty.
  localparam int unsigned IF_ID_DATA_W  = 96;
  localparam int unsigned IF_ID_CTRL_W  = 1;
  localparam int unsigned ID_EX_DATA_W  = 175;
  localparam int unsigned ID_EX_CTRL_W  = 10;
  localparam int unsigned EX_MEM_DATA_W = 101;
  localparam int unsigned EX_MEM_CTRL_W = 4;
  localparam int unsigned MEM_WB_DATA_W = 101;
  localparam int unsigned MEM_WB_CTRL_W = 3;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_data_t;

  typedef struct packed {
    logic rsvd;
  } if_id_ctrl_t;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm_ext;
    logic [31:0] pc_plus4;
  } id_ex_data_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } ex_mem_data_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } mem_wb_data_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } mem_wb_ctrl_t;

endpackage

// File: rtl/pipe_skid_entry.sv
// One valid/data/control slot. Priority: reset, flush, load, clear.
// Flush and clear drop the valid bit; flush also zeroes control, data is left as is.
module pipe_skid_entry
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = EX_MEM_DATA_W,
  parameter int unsigned CTRL_W = EX_MEM_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic              flush,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

  // Load beats clear so a slot can drain and refill on the same edge.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      ctrl_d  = load_ctrl;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic flow-controlled pipeline stage register with flush and bubble gating of control.
// PIPE_STAGE_SKID_EN adds a skid slot so in_ready comes straight from a flop.
module pipe_stage_reg
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = EX_MEM_DATA_W,
  parameter int unsigned CTRL_W = EX_MEM_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
);

  // Handshake: a bundle moves across a port on a rising edge where both valid
  // and ready are high; valid never waits on ready, and a held output is stable.
  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              main_load;
  logic              main_clear;
  logic [DATA_W-1:0] main_load_data;
  logic [CTRL_W-1:0] main_load_ctrl;
  logic              in_fire;
  logic              main_take;

  assign in_fire   = in_valid && in_ready;
  assign main_take = main_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              skid_load;
  logic              skid_clear;

  // in_ready is low whenever skid holds a bundle, so skid refill and input never collide.
  always_comb begin
    main_load      = 1'b0;
    main_clear     = main_take;
    main_load_data = in_data;
    main_load_ctrl = in_ctrl;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (skid_valid) begin
      if (main_take) begin
        main_load      = 1'b1;
        main_load_data = skid_data;
        main_load_ctrl = skid_ctrl;
        skid_clear     = 1'b1;
      end
    end else if (in_fire) begin
      if (!main_valid || main_take) begin
        main_load = 1'b1;
      end else begin
        skid_load = 1'b1;
      end
    end
  end

  assign in_ready = !skid_valid;

  pipe_skid_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .clear     (skid_clear),
    .flush     (flush),
    .load_data (in_data),
    .load_ctrl (in_ctrl),
    .valid     (skid_valid),
    .data      (skid_data),
    .ctrl      (skid_ctrl)
  );
`else
  always_comb begin
    main_load      = in_fire;
    main_clear     = main_take;
    main_load_data = in_data;
    main_load_ctrl = in_ctrl;
  end

  assign in_ready = !main_valid || out_ready;
`endif

  pipe_skid_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk       (clk),
    .reset     (reset),
    .load      (main_load),
    .clear     (main_clear),
    .flush     (flush),
    .load_data (main_load_data),
    .load_ctrl (main_load_ctrl),
    .valid     (main_valid),
    .data      (main_data),
    .ctrl      (main_ctrl)
  );

  // Control is gated combinationally so a bubble can never carry write enables.
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register for the RISC-V pipeline, replacing the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries a data bundle and a control bundle between stages with a valid/ready handshake, stall back-pressure and synchronous flush. When a bubble or flush occurs, the control bundle is forced to zero so downstream stages never see a spurious RegWrite or MemWrite.

## Interface
Parameters:
- DATA_W, 101 — width of the data bundle (default ALUResult 32 + WriteData 32 + PCPlus4 32 + Rd 5).
- CTRL_W, 4 — width of the control bundle (default RegWrite 1 + ResultSrc 2 + MemWrite 1); zeroed on reset, flush and bubble.

Ports:
- clk  in  1  clock; one clock domain, all state updates on posedge clk.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream stage presents a valid bundle.
- in_ready  out  1  stage can accept a bundle this cycle.
- in_data  in  DATA_W  upstream data bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- flush  in  1  discard all held and incoming bundles (branch mispredict / hazard unit).
- out_valid  out  1  bundle presented to downstream stage.
- out_ready  in  1  downstream accepts the bundle (stall = 0).
- out_data  out  DATA_W  held data bundle.
- out_ctrl  out  CTRL_W  held control bundle; all-zero whenever out_valid = 0.

## Operation
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- Storage: main register (drives outputs) plus one skid entry. Each entry has a valid bit, data and control.
- Main entry empty, or main transfers out this cycle: an accepted input loads main.
- Main entry full, out_ready = 0, input accepted: the input loads the skid entry.
- Skid entry full and main transfers out: skid moves to main. A simultaneous accepted input is not possible because in_ready = 0.
- Ordering is strictly FIFO and no bundle is duplicated or dropped, except on flush or reset.
- Flush has the highest priority after reset. On the next edge both valid bits are 0 and both control fields are 0. An input handshaken in the flush cycle is discarded. Data fields keep their old values; they are don't-care.
- Reset: both valid bits are 0, all data and control are 0. Reset overrides flush and all transfers.
- Reset value of every output:
  - out_valid = 0.
  - out_data = 0.
  - out_ctrl = 0.
  - in_ready = 1 in both configurations: the skid entry is empty and main is empty.
- out_ctrl = ctrl_main & {CTRL_W{out_valid}}. This is combinational gating, so a bubble never carries write enables.
- No arithmetic. Widths pass through unchanged; no truncation or extension.

## Timing
- Latency: 1 cycle from input transfer to out_valid, when main is empty or draining.
- Throughput: 1 bundle/cycle sustained while out_ready = 1.
- in_ready = !skid_valid is driven directly from a flop, with no combinational path from out_ready.
- Stall: after out_ready falls, at most 1 further bundle is accepted (into skid); in_ready drops the following cycle.
- Stall release: the skid bundle reaches main on the first edge with out_ready = 1, and in_ready rises on that same edge.
- While out_valid = 1 and out_ready = 0, out_data and out_ctrl are stable.

## Configuration
- PIPE_STAGE_SKID_EN defined: skid entry present, registered in_ready, behaviour as above.
- PIPE_STAGE_SKID_EN undefined: no skid entry; only the main register is present.
  - in_ready = !out_valid || out_ready, a combinational path from out_ready.
  - Latency, flush, reset and bubble-gating are identical.
  - Under stall, no bundle is accepted beyond the one held in main.

## Structure
- Shared package riscv_pipe_pkg holds:
  - the per-stage bundle widths as localparams: EX_MEM_DATA_W = 101 and EX_MEM_CTRL_W = 4, with equivalents for the other stages;
  - packed struct typedefs for each stage's data and control bundles, so instantiations cast to and from the flat ports.
- One sub-module: pipe_skid_entry, holding one valid/data/control slot with load, clear and flush inputs. It is instantiated for main always and for skid only under PIPE_STAGE_SKID_EN.

## Test plan
- Reset then idle: reset = 1 for 2 cycles with in_valid = 1 → out_valid = 0, out_ctrl = 0, out_data = 0, in_ready = 1.
- Streaming: 8 back-to-back bundles with data = 0x1..0x8 and ctrl = 4'b1011, out_ready = 1 → same sequence at the output, 1 cycle later, 1 per cycle.
- Stall with skid: stream bundles A, B, C; drop out_ready while A is on the output → A held, B enters skid, in_ready = 0 the next cycle; raise out_ready after 3 cycles → A, B, C emitted in order, none lost or repeated. Without the macro, in_ready = 0 during the stall.
- Flush: main and skid both full, flush = 1 with in_valid = 1 → next cycle out_valid = 0, out_ctrl = 0, in_ready = 1; the following bundle 0x55 appears 1 cycle after acceptance.
- Bubble gating: in_valid = 0 with in_ctrl = 4'b1111 → out_ctrl stays 0 and out_valid = 0.
- Reset mid-stall: skid full, out_ready = 0, assert reset → all valid bits 0 on the next edge; no stale bundle is emitted after reset deasserts.
